// File: rtl/tracklet_calc_sdiv_31s_16ns.sv
// Signed 31-bit by unsigned 16-bit divider: restoring shift-subtract, one quotient bit per cycle,
// with saturation to a 17-bit signed quotient and divide-by-zero reporting.
module tracklet_calc_sdiv_31s_16ns #(
  parameter logic [31:0] ID = 32'd1
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [30:0] dividend,
  input  logic [15:0] divisor,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [16:0] quotient,
  output logic [16:0] remainder,
  output logic        ovf,
  output logic        dbz
);

  localparam int unsigned DVD_W = 31;
  localparam int unsigned DVS_W = 16;
  localparam int unsigned RES_W = 17;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q;
  logic [DVD_W-1:0]   mag_q;
  logic [DVD_W-1:0]   quo_q;
  logic [RES_W-1:0]   rem_q;
  logic [DVS_W-1:0]   div_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               neg_q;
  logic               zero_q;
  logic               din_ready_q;
  logic               dout_valid_q;
  logic [RES_W-1:0]   quotient_q;
  logic [RES_W-1:0]   remainder_q;
  logic               ovf_q;
  logic               dbz_q;

  logic [RES_W:0]     trial_d;
  logic               ge_d;
  logic [RES_W-1:0]   rem_d;
  logic [DVD_W-1:0]   abs_d;
  logic [RES_W-1:0]   rmag_d;
  logic [RES_W-1:0]   quo_fin_d;
  logic [RES_W-1:0]   rem_fin_d;
  logic               ovf_fin_d;
  logic               dbz_fin_d;

  logic unused_id;
  assign unused_id = ^ID;

  // One restoring step plus the signed/saturated result formed from the finished magnitudes.
  always_comb begin
    trial_d   = {rem_q, mag_q[DVD_W-1]};
    ge_d      = (trial_d >= (RES_W+1)'(div_q));
    rem_d     = ge_d ? RES_W'(trial_d - (RES_W+1)'(div_q)) : RES_W'(trial_d);
    abs_d     = dividend[DVD_W-1] ? DVD_W'(~dividend + DVD_W'(1)) : dividend;
    rmag_d    = {1'b0, rem_q[DVS_W-1:0]};
    quo_fin_d = '0;
    rem_fin_d = '0;
    ovf_fin_d = 1'b0;
    dbz_fin_d = 1'b0;
    if (div_q == '0) begin
      dbz_fin_d = 1'b1;
      if (!zero_q) quo_fin_d = neg_q ? 17'h10000 : 17'h0FFFF;
    end else if (!neg_q && (quo_q > DVD_W'(65535))) begin
      quo_fin_d = 17'h0FFFF;
      ovf_fin_d = 1'b1;
    end else if (neg_q && (quo_q > DVD_W'(65536))) begin
      quo_fin_d = 17'h10000;
      ovf_fin_d = 1'b1;
    end else begin
      quo_fin_d = neg_q ? RES_W'(~quo_q[RES_W-1:0] + RES_W'(1)) : quo_q[RES_W-1:0];
      rem_fin_d = neg_q ? RES_W'(~rmag_d + RES_W'(1)) : rmag_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      mag_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      div_q        <= '0;
      cnt_q        <= '0;
      neg_q        <= 1'b0;
      zero_q       <= 1'b0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      quotient_q   <= '0;
      remainder_q  <= '0;
      ovf_q        <= 1'b0;
      dbz_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            mag_q       <= abs_d;
            neg_q       <= dividend[DVD_W-1];
            zero_q      <= (dividend == '0);
            div_q       <= divisor;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            din_ready_q <= 1'b0;
            state_q     <= CALC;
          end
        end
        CALC: begin
          // Counter reaches 31 after the 31st quotient bit; the next edge publishes the result.
          if (cnt_q == CNT_W'(31)) begin
            quotient_q   <= quo_fin_d;
            remainder_q  <= rem_fin_d;
            ovf_q        <= ovf_fin_d;
            dbz_q        <= dbz_fin_d;
            dout_valid_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= {quo_q[DVD_W-2:0], ge_d};
            mag_q <= {mag_q[DVD_W-2:0], 1'b0};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          din_ready_q  <= 1'b1;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign quotient   = quotient_q;
  assign remainder  = remainder_q;
  assign ovf        = ovf_q;
  assign dbz        = dbz_q;

endmodule

// File: tb/tb_tracklet_calc_sdiv_31s_16ns.sv
// Scoreboard bench for the 31s/16u divider: driver queues hand-computed results, monitor checks them.
module tb_tracklet_calc_sdiv_31s_16ns;

  logic        ap_clk;
  logic        ap_rst;
  logic        din_valid;
  logic        din_ready;
  logic [30:0] dividend;
  logic [15:0] divisor;
  logic        dout_valid;
  logic        dout_ready;
  logic [16:0] quotient;
  logic [16:0] remainder;
  logic        ovf;
  logic        dbz;

  typedef struct {
    logic [16:0] q;
    logic [16:0] r;
    logic        o;
    logic        z;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  tracklet_calc_sdiv_31s_16ns #(.ID(32'd1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .dividend(dividend), .divisor(divisor),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, expv, expv);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting on the DUT", nm);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_din_ready"}, 32'(din_ready), 32'd1);
    chk({nm, "_dout_valid"}, 32'(dout_valid), 32'd0);
    chk({nm, "_quotient"}, 32'(quotient), 32'd0);
    chk({nm, "_remainder"}, 32'(remainder), 32'd0);
    chk({nm, "_ovf"}, 32'(ovf), 32'd0);
    chk({nm, "_dbz"}, 32'(dbz), 32'd0);
  endtask

  // Issue one pair, scramble inputs during CALC, and optionally stall the consumer in DONE.
  task automatic run_vec(input int dvd, input int dvs, input int eq, input int er,
                         input bit eo, input bit ez, input bit hold);
    exp_t e;
    int   k;
    @(negedge ap_clk);
    dividend   = 31'(dvd);
    divisor    = 16'(dvs);
    din_valid  = 1'b1;
    dout_ready = !hold;
    k = 0;
    while (din_ready !== 1'b1 && k < 50) begin @(negedge ap_clk); k++; end
    if (din_ready !== 1'b1) timeout("accept");
    e.q = 17'(eq); e.r = 17'(er); e.o = eo; e.z = ez; e.cyc = cyc + 33;
    sb.push_back(e);
    @(negedge ap_clk);
    din_valid = 1'b0;
    repeat (5) begin
      dividend = 31'($urandom);
      divisor  = 16'($urandom);
      din_valid = 1'($urandom);
      @(negedge ap_clk);
    end
    din_valid = 1'b0;
    k = 0;
    while (dout_valid !== 1'b1 && k < 60) begin @(negedge ap_clk); k++; end
    if (dout_valid !== 1'b1) timeout("dout_valid");
    if (hold) begin
      repeat (10) begin
        @(negedge ap_clk);
        chk("hold_valid", 32'(dout_valid), 32'd1);
        chk("hold_din_ready", 32'(din_ready), 32'd0);
        chk("hold_quotient", 32'(quotient), 32'(17'(eq)));
        chk("hold_remainder", 32'(remainder), 32'(17'(er)));
        chk("hold_flags", 32'({ovf, dbz}), 32'({eo, ez}));
      end
      dout_ready = 1'b1;
      @(negedge ap_clk);
      chk("release_valid", 32'(dout_valid), 32'd0);
      chk("release_din_ready", 32'(din_ready), 32'd1);
    end else begin
      k = 0;
      while (din_ready !== 1'b1 && k < 10) begin @(negedge ap_clk); k++; end
      if (din_ready !== 1'b1) timeout("return_idle");
    end
  endtask

  // Monitor: compare each new result against the oldest queued expectation, including latency.
  initial begin : monitor
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge ap_clk);
      if (dout_valid === 1'b1 && !prev_v) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: quotient %0h with no pending operation", quotient);
        end else begin
          e = sb.pop_front();
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          chk("quotient", 32'(quotient), 32'(e.q));
          chk("remainder", 32'(remainder), 32'(e.r));
          chk("ovf", 32'(ovf), 32'(e.o));
          chk("dbz", 32'(dbz), 32'(e.z));
        end
      end
      prev_v = (dout_valid === 1'b1);
    end
  end

  initial begin : driver
    int k;
    ap_rst     = 1'b1;
    din_valid  = 1'b0;
    dividend   = '0;
    divisor    = '0;
    dout_ready = 1'b1;
    repeat (3) @(negedge ap_clk);
    check_reset_vals("reset");
    ap_rst = 1'b0;

    run_vec(1000, 7, 142, 6, 1'b0, 1'b0, 1'b0);
    run_vec(-1000, 7, -142, -6, 1'b0, 1'b0, 1'b0);
    run_vec(-6, 7, 0, -6, 1'b0, 1'b0, 1'b0);
    run_vec(1073741823, 1, 65535, 0, 1'b1, 1'b0, 1'b0);
    run_vec(-1073741824, 16384, -65536, 0, 1'b0, 1'b0, 1'b0);
    run_vec(5, 0, 65535, 0, 1'b0, 1'b1, 1'b0);
    run_vec(-5, 0, -65536, 0, 1'b0, 1'b1, 1'b0);
    run_vec(0, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    run_vec(65535, 1, 65535, 0, 1'b0, 1'b0, 1'b0);
    run_vec(65536, 1, 65535, 0, 1'b1, 1'b0, 1'b0);
    run_vec(-65536, 1, -65536, 0, 1'b0, 1'b0, 1'b0);
    run_vec(-65537, 1, -65536, 0, 1'b1, 1'b0, 1'b0);
    run_vec(-1073741824, 65535, -16384, -16384, 1'b0, 1'b0, 1'b0);
    run_vec(123456789, 40000, 3086, 16789, 1'b0, 1'b0, 1'b1);

    // Abort an operation mid-CALC with reset while the inputs churn.
    @(negedge ap_clk);
    dividend  = 31'(12345);
    divisor   = 16'(3);
    din_valid = 1'b1;
    k = 0;
    while (din_ready !== 1'b1 && k < 50) begin @(negedge ap_clk); k++; end
    @(negedge ap_clk);
    repeat (15) begin
      dividend  = 31'($urandom);
      divisor   = 16'($urandom);
      din_valid = 1'($urandom);
      @(negedge ap_clk);
    end
    ap_rst     = 1'b1;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    @(negedge ap_clk);
    check_reset_vals("mid_calc_reset");
    ap_rst    = 1'b0;
    din_valid = 1'b0;
    run_vec(100, 10, 10, 0, 1'b0, 1'b0, 1'b0);

    k = 0;
    while (sb.size() != 0 && k < 100) begin @(negedge ap_clk); k++; end
    if (sb.size() != 0) timeout("scoreboard_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
